lcd_bus_driver: RTL and testbench
=================================

// Module: lcd_bus_driver
// PURPOSE
//  Downstream of the LCD source mux. Consumes the selected write request (wr, dr, db, direc) and
//  drives the HD44780-compatible character LCD pins with correct setup, enable-pulse, hold and
//  execution timing. Repositions the DDRAM address automatically and reports busy/done to the sources.
// PARAMETERS
//  T_SETUP  2       clk cycles: RS/DATA stable before E rises
//  T_EPW    12      clk cycles: E high width
//  T_HOLD   2       clk cycles: RS/DATA held after E falls
//  T_EXEC   2000    clk cycles: execution wait, normal command or data write
//  T_LONG   82000   clk cycles: execution wait, clear/home (db = 0x01..0x03, dr = 0)
//  T_PWRUP  750000  clk cycles: power-up wait after reset
//  CNT_W    20      timer width; must hold the largest T_* value
// PORTS
//  clk       in   1  system clock
//  reset     in   1  asynchronous, active-high reset
//  wr        in   1  write request; accepted only when busy = 0
//  dr        in   1  1 = data byte to DDRAM at direc; 0 = command byte db
//  db        in   8  command or data byte
//  direc     in   8  DDRAM address for data writes; bit 7 is ignored
//  busy      out  1  1 = request not accepted (power-up or transfer in progress)
//  done      out  1  one-cycle pulse; the accepted request has completed
//  lcd_e     out  1  LCD enable
//  lcd_rs    out  1  LCD register select (0 = command, 1 = data)
//  lcd_rw    out  1  LCD read/write; constant 0 (write-only)
//  lcd_data  out  8  LCD data bus
// BEHAVIOUR
//  - Reset (async, any state): state = PWRUP, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0x00,
//    busy = 1, done = 0, cur_valid = 0, timer = 0. lcd_e falls immediately, even mid-pulse.
//  - FSM states: PWRUP, IDLE, SETUP, EHI, HOLD, EXEC. One timer is reloaded on every state entry.
//  - PWRUP: hold for T_PWRUP cycles, then go to IDLE. wr is ignored here.
//  - IDLE: busy = 0. On a cycle with wr = 1:
//      - capture db, dr and direc[6:0];
//      - busy = 1 from the next cycle;
//      - wr while busy = 1 is dropped; the source must re-request.
//  - Transfer list for an accepted request:
//      - dr = 0: one transfer, {rs=0, db}.
//      - dr = 1 and (cur_valid = 0 or direc[6:0] != cursor): two transfers, {rs=0, 0x80|direc[6:0]}
//        then {rs=1, db}.
//      - dr = 1 and cursor match: one transfer, {rs=1, db}.
//  - Per transfer: SETUP (T_SETUP cycles), EHI (T_EPW, lcd_e = 1), HOLD (T_HOLD), EXEC (T_EXEC, or
//    T_LONG for clear/home). lcd_rs and lcd_data are valid from SETUP entry through HOLD end.
//  - Latency per transfer = T_SETUP + T_EPW + T_HOLD + wait.
//  - done is asserted in the last EXEC cycle of the final transfer. The next state is IDLE and busy
//    falls on that edge. There is no IDLE gap between the two transfers of a request.
//  - Cursor tracking (7-bit):
//      - data write: cursor = cursor + 1, wrapping 0x7F -> 0x00;
//      - command with db[7] = 1: cursor = db[6:0], cur_valid = 1;
//      - any other command: cur_valid = 0.
//  - lcd_data and lcd_rs keep their last values in IDLE and EXEC. lcd_rw is never driven to 1.
// CONFIGURATION
//  LCD_4BIT_EN defined:
//    - each byte is sent as two E pulses, high nibble first, on lcd_data[7:4]; lcd_data[3:0] = 0;
//    - sequence per byte: SETUP, EHI, HOLD for the high nibble, then SETUP, EHI, HOLD for the low
//      nibble, then one EXEC;
//    - no execution wait between the two nibbles.
//  LCD_4BIT_EN undefined: a single E pulse per byte carries all 8 bits on lcd_data.
// TESTING (T_SETUP=1, T_EPW=3, T_HOLD=1, T_EXEC=10, T_LONG=40, T_PWRUP=50, 8-bit unless noted)
//  1. Release reset, pulse wr at cycle 10 -> busy = 1 for 50 cycles, no lcd_e pulse, that wr is lost.
//  2. wr, dr=0, db=0x38 -> one 3-cycle lcd_e pulse with rs=0, data=0x38; done 15 cycles after accept.
//     With LCD_4BIT_EN: two pulses carrying 0x30 then 0x80; done after 20 cycles.
//  3. After a cursor-invalidating command, wr, dr=1, db=0x41, direc=0x40 -> pulse {rs=0, 0xC0} then
//     pulse {rs=1, 0x41}; a single done after 30 cycles.
//  4. Then wr, dr=1, db=0x42, direc=0x41 -> single pulse {rs=1, 0x42}; no address command.
//  5. wr, dr=0, db=0x01 -> EXEC lasts 40 cycles. A following data write to direc=0x41 issues 0xC1
//     first (cursor invalid).
//  6. Assert reset during EHI -> lcd_e = 0 in the same cycle; the block restarts PWRUP; no done.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD bus driver: setup/E-pulse/hold/execute sequencing with automatic DDRAM repositioning.
// Optional LCD_4BIT_EN sends each byte as two nibble pulses on lcd_data[7:4].
module lcd_bus_driver #(
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_LONG  = 82000,
  parameter int T_PWRUP = 750000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] db,
  input  logic [7:0] direc,
  output logic       busy,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_EHI, S_HOLD, S_EXEC
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       data_q, data_d;
  logic             second_q, second_d;
  logic [6:0]       cursor_q, cursor_d;
  logic             cur_valid_q, cur_valid_d;
`ifdef LCD_4BIT_EN
  logic             nib_lo_q, nib_lo_d;
`endif

  logic [CNT_W-1:0] lim;
  logic             last, is_long, start_xfer, nxt_rs, done_c;
  logic [7:0]       nxt_byte;

  assign is_long = !lcd_rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  always_comb begin
    lim = CNT_W'(1);
    case (state_q)
      S_PWRUP: lim = CNT_W'(T_PWRUP);
      S_SETUP: lim = CNT_W'(T_SETUP);
      S_EHI:   lim = CNT_W'(T_EPW);
      S_HOLD:  lim = CNT_W'(T_HOLD);
      S_EXEC:  lim = is_long ? CNT_W'(T_LONG) : CNT_W'(T_EXEC);
      default: lim = CNT_W'(1);
    endcase
  end

  assign last = (timer_q == lim - 1'b1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    byte_d      = byte_q;
    data_d      = data_q;
    second_d    = second_q;
    cursor_d    = cursor_q;
    cur_valid_d = cur_valid_q;
`ifdef LCD_4BIT_EN
    nib_lo_d    = nib_lo_q;
`endif
    start_xfer  = 1'b0;
    nxt_byte    = byte_q;
    nxt_rs      = lcd_rs_q;
    done_c      = 1'b0;

    case (state_q)
      S_PWRUP: if (last) begin
        state_d = S_IDLE;
        timer_d = '0;
      end
      S_IDLE: begin
        timer_d = '0;
        if (wr) begin
          data_d     = db;
          start_xfer = 1'b1;
          // Cursor is updated for the whole request at accept; an address command
          // followed by the data write nets out to direc + 1.
          if (dr) begin
            cursor_d    = direc[6:0] + 7'd1;
            cur_valid_d = 1'b1;
            if (!cur_valid_q || direc[6:0] != cursor_q) begin
              nxt_byte = {1'b1, direc[6:0]};
              nxt_rs   = 1'b0;
              second_d = 1'b1;
            end else begin
              nxt_byte = db;
              nxt_rs   = 1'b1;
              second_d = 1'b0;
            end
          end else begin
            nxt_byte = db;
            nxt_rs   = 1'b0;
            second_d = 1'b0;
            if (db[7]) begin
              cursor_d    = db[6:0];
              cur_valid_d = 1'b1;
            end else begin
              cur_valid_d = 1'b0;
            end
          end
        end
      end
      S_SETUP: if (last) begin
        state_d = S_EHI;
        timer_d = '0;
      end
      S_EHI: if (last) begin
        state_d = S_HOLD;
        timer_d = '0;
      end
      S_HOLD: if (last) begin
        timer_d = '0;
`ifdef LCD_4BIT_EN
        if (!nib_lo_q) begin
          state_d    = S_SETUP;
          nib_lo_d   = 1'b1;
          lcd_data_d = {byte_q[3:0], 4'h0};
        end else begin
          state_d = S_EXEC;
        end
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: if (last) begin
        if (second_q) begin
          start_xfer = 1'b1;
          nxt_byte   = data_q;
          nxt_rs     = 1'b1;
          second_d   = 1'b0;
        end else begin
          done_c  = 1'b1;
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_PWRUP;
        timer_d = '0;
      end
    endcase

    if (start_xfer) begin
      state_d  = S_SETUP;
      timer_d  = '0;
      byte_d   = nxt_byte;
      lcd_rs_d = nxt_rs;
`ifdef LCD_4BIT_EN
      nib_lo_d   = 1'b0;
      lcd_data_d = {nxt_byte[7:4], 4'h0};
`else
      lcd_data_d = nxt_byte;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      timer_q     <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
      byte_q      <= '0;
      data_q      <= '0;
      second_q    <= 1'b0;
      cursor_q    <= '0;
      cur_valid_q <= 1'b0;
`ifdef LCD_4BIT_EN
      nib_lo_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      byte_q      <= byte_d;
      data_q      <= data_d;
      second_q    <= second_d;
      cursor_q    <= cursor_d;
      cur_valid_q <= cur_valid_d;
`ifdef LCD_4BIT_EN
      nib_lo_q    <= nib_lo_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_c;
  assign lcd_e    = (state_q == S_EHI);
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: a request-level model queues expected E pulses and done latency.
module tb_lcd_bus_driver;

  localparam int TS = 1, TE = 3, TH = 1, TX = 10, TL = 40, TP = 50;
`ifdef LCD_4BIT_EN
  localparam int NPULSE = 2;
`else
  localparam int NPULSE = 1;
`endif

  logic       clk = 1'b0, reset = 1'b1, wr = 1'b0, dr = 1'b0;
  logic [7:0] db = '0, direc = '0;
  logic       busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_bus_driver #(
    .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH), .T_EXEC(TX),
    .T_LONG(TL), .T_PWRUP(TP), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .dr(dr), .db(db), .direc(direc),
    .busy(busy), .done(done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int stim; int lat; } done_t;
  logic [8:0] pulse_q[$];
  done_t      done_q[$];
  int n_cmp = 0, n_err = 0;

  int m_cur = 0;
  bit m_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every E pulse and every done pulse against queued expectations.
  bit prev_e = 0;
  int e_start = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_e = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        e_start = cyc;
        if (pulse_q.size() == 0) begin
          chk("unexpected_pulse", {23'd0, lcd_rs, lcd_data}, 'h1ff);
        end else begin
          logic [8:0] exp_p;
          exp_p = pulse_q.pop_front();
          chk("pulse_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_p});
          chk("lcd_rw", {31'd0, lcd_rw}, 0);
        end
      end
      if (!lcd_e && prev_e) chk("pulse_width", cyc - e_start, TE);
      prev_e = lcd_e;
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_latency", cyc - d.stim, d.lat);
        end
      end
    end
  end

  // Reference model: spec transfer list and cursor rules, applied per request.
  task automatic issue(input logic d, input logic [7:0] b, input logic [7:0] a);
    logic [7:0] bytes[$];
    bit         rss[$];
    int         lat = 0;
    if (d) begin
      if (!m_valid || int'(a[6:0]) != m_cur) begin
        bytes.push_back(8'h80 | {1'b0, a[6:0]});
        rss.push_back(0);
      end
      bytes.push_back(b);
      rss.push_back(1);
    end else begin
      bytes.push_back(b);
      rss.push_back(0);
    end
    foreach (bytes[i]) begin
      logic [7:0] x;
      x = bytes[i];
`ifdef LCD_4BIT_EN
      pulse_q.push_back({rss[i], x[7:4], 4'h0});
      pulse_q.push_back({rss[i], x[3:0], 4'h0});
`else
      pulse_q.push_back({rss[i], x});
`endif
      lat += NPULSE * (TS + TE + TH) + ((!rss[i] && x >= 1 && x <= 3) ? TL : TX);
      if (rss[i]) m_cur = (m_cur + 1) % 128;
      else if (x >= 8'h80) begin m_cur = int'(x) - 128; m_valid = 1; end
      else m_valid = 0;
    end
    done_q.push_back('{cyc, lat});
    wr = 1'b1; dr = d; db = b; direc = a;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Counts power-up busy cycles while a dropped wr is pulsed at cycle 10.
  task automatic check_pwrup();
    int n = 0;
    while (busy && n < 200) begin
      wr = (n == 10);
      db = 8'h38;
      @(negedge clk);
      n++;
    end
    wr = 1'b0;
    chk("pwrup_busy_cycles", n, TP);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 1);
    chk("reset_lcd_e", {31'd0, lcd_e}, 0);
    chk("reset_bus", {23'd0, lcd_rs, lcd_data}, 0);
    chk("reset_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    check_pwrup();

    issue(0, 8'h38, 8'h00); wait_idle();
    issue(1, 8'h41, 8'h40); wait_idle();
    issue(1, 8'h42, 8'h41); wait_idle();
    issue(0, 8'h01, 8'h00); wait_idle();
    issue(1, 8'h55, 8'hC1); wait_idle();

    for (int k = 0; k < 40; k++) begin
      logic       d;
      logic [7:0] b, a;
      d = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (!d && $urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 3));
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a = {a[7], 7'(m_cur)};
      issue(d, b, a);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        wr = busy;
        db = 8'($urandom);
        dr = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      wr = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    issue(0, 8'h0C, 8'h00);
    begin
      int n = 0;
      while (!lcd_e && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reach_ehi", {31'd0, lcd_e}, 1);
    end
    reset = 1'b1;
    #1;
    chk("async_e_low", {31'd0, lcd_e}, 0);
    chk("async_busy", {31'd0, busy}, 1);
    chk("async_bus", {23'd0, lcd_rs, lcd_data}, 0);
    pulse_q.delete();
    done_q.delete();
    m_valid = 0;
    m_cur = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_pwrup();

    issue(1, 8'h61, 8'h05); wait_idle();
    issue(1, 8'h62, 8'h06); wait_idle();
    repeat (5) @(negedge clk);
    chk("pulses_left", pulse_q.size(), 0);
    chk("dones_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
